// File: rtl/vfp_axi4lite_regfile.sv
// vfp_axi4lite_regfile
// AXI4-Lite slave holding four 32-bit configuration registers for the VFP
// video pipeline. Writes are byte-strobed and accept AW and W in any order.
// Reads return registered data one cycle after the AR handshake. Every
// committed write raises a one-cycle strobe for its register.

module vfp_axi4lite_regfile #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 4
) (
   input  logic                            clock,
   input  logic                            reset,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
   input  logic [2:0]                      s_axi_awprot,
   input  logic                            s_axi_awvalid,
   output logic                            s_axi_awready,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
   input  logic                            s_axi_wvalid,
   output logic                            s_axi_wready,
   output logic [1:0]                      s_axi_bresp,
   output logic                            s_axi_bvalid,
   input  logic                            s_axi_bready,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
   input  logic [2:0]                      s_axi_arprot,
   input  logic                            s_axi_arvalid,
   output logic                            s_axi_arready,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
   output logic [1:0]                      s_axi_rresp,
   output logic                            s_axi_rvalid,
   input  logic                            s_axi_rready,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   cfg_reg0,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   cfg_reg1,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   cfg_reg2,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   cfg_reg3,
   output logic [3:0]                      cfg_wr_pulse
);

   localparam int NUM_BYTES = C_S_AXI_DATA_WIDTH / 8;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      W_IDLE,
      W_HAVE_AW,
      W_HAVE_W,
      W_RESP
   } w_state_t;

   typedef enum logic {
      R_IDLE,
      R_RESP
   } r_state_t;

   w_state_t w_state;
   w_state_t w_state_next;
   r_state_t r_state;
   r_state_t r_state_next;

   logic [C_S_AXI_DATA_WIDTH-1:0] regs [4];

   logic [C_S_AXI_ADDR_WIDTH-1:0] aw_addr_q;
   logic [C_S_AXI_DATA_WIDTH-1:0] w_data_q;
   logic [NUM_BYTES-1:0]          w_strb_q;

   logic                          aw_hs;
   logic                          w_hs;
   logic                          ar_hs;
   logic                          commit;
   logic [C_S_AXI_ADDR_WIDTH-1:0] commit_addr;
   logic [C_S_AXI_DATA_WIDTH-1:0] commit_data;
   logic [NUM_BYTES-1:0]          commit_strb;
   logic [1:0]                    commit_idx;
   logic                          commit_oor;
   logic [1:0]                    read_idx;
   logic                          read_oor;
   logic                          unused_bits;

   // Anything above the 16-byte register window is an out-of-range access
   function automatic logic addr_out_of_range(input logic [C_S_AXI_ADDR_WIDTH-1:0] a);
      return (a >> 4) != '0;
   endfunction

   assign aw_hs = s_axi_awvalid && s_axi_awready;
   assign w_hs  = s_axi_wvalid  && s_axi_wready;
   assign ar_hs = s_axi_arvalid && s_axi_arready;

   assign cfg_reg0 = regs[0];
   assign cfg_reg1 = regs[1];
   assign cfg_reg2 = regs[2];
   assign cfg_reg3 = regs[3];

   assign unused_bits = ^{s_axi_awprot, s_axi_arprot, commit_addr[1:0], s_axi_araddr[1:0]};

   // Write channel next state; the commit takes whichever of address/data was latched earlier
   always_comb begin
      w_state_next = w_state;
      commit       = 1'b0;
      commit_addr  = s_axi_awaddr;
      commit_data  = s_axi_wdata;
      commit_strb  = s_axi_wstrb;
      case (w_state)
         W_IDLE: begin
            if (aw_hs && w_hs) begin
               commit       = 1'b1;
               w_state_next = W_RESP;
            end else if (aw_hs) begin
               w_state_next = W_HAVE_AW;
            end else if (w_hs) begin
               w_state_next = W_HAVE_W;
            end
         end
         W_HAVE_AW: begin
            commit_addr = aw_addr_q;
            if (w_hs) begin
               commit       = 1'b1;
               w_state_next = W_RESP;
            end
         end
         W_HAVE_W: begin
            commit_data = w_data_q;
            commit_strb = w_strb_q;
            if (aw_hs) begin
               commit       = 1'b1;
               w_state_next = W_RESP;
            end
         end
         W_RESP: begin
            if (s_axi_bready) begin
               w_state_next = W_IDLE;
            end
         end
         default: begin
            w_state_next = W_IDLE;
         end
      endcase
   end

   assign commit_idx = commit_addr[3:2];
   assign commit_oor = addr_out_of_range(commit_addr);

   // Write state register with readies registered from the next state
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         w_state       <= W_IDLE;
         s_axi_awready <= 1'b0;
         s_axi_wready  <= 1'b0;
      end else begin
         w_state       <= w_state_next;
         s_axi_awready <= (w_state_next == W_IDLE) || (w_state_next == W_HAVE_W);
         s_axi_wready  <= (w_state_next == W_IDLE) || (w_state_next == W_HAVE_AW);
      end
   end

   // Hold whichever write channel arrived first until its partner shows up
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         aw_addr_q <= '0;
         w_data_q  <= '0;
         w_strb_q  <= '0;
      end else begin
         if (aw_hs) begin
            aw_addr_q <= s_axi_awaddr;
         end
         if (w_hs) begin
            w_data_q <= s_axi_wdata;
            w_strb_q <= s_axi_wstrb;
         end
      end
   end

   // Commit a write to the register bank, raise its strobe and post the B response
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int r = 0; r < 4; r++) begin
            regs[r] <= '0;
         end
         cfg_wr_pulse <= '0;
         s_axi_bvalid <= 1'b0;
         s_axi_bresp  <= RESP_OKAY;
      end else begin
         cfg_wr_pulse <= '0;
         if (commit) begin
            s_axi_bvalid <= 1'b1;
            s_axi_bresp  <= commit_oor ? RESP_SLVERR : RESP_OKAY;
            if (!commit_oor) begin
               cfg_wr_pulse[commit_idx] <= 1'b1;
               for (int b = 0; b < NUM_BYTES; b++) begin
                  if (commit_strb[b]) begin
                     regs[commit_idx][8*b +: 8] <= commit_data[8*b +: 8];
                  end
               end
            end
         end else if (s_axi_bvalid && s_axi_bready) begin
            s_axi_bvalid <= 1'b0;
         end
      end
   end

   // Read channel next state: a single response slot
   always_comb begin
      r_state_next = r_state;
      case (r_state)
         R_IDLE: begin
            if (ar_hs) begin
               r_state_next = R_RESP;
            end
         end
         R_RESP: begin
            if (s_axi_rready) begin
               r_state_next = R_IDLE;
            end
         end
         default: begin
            r_state_next = R_IDLE;
         end
      endcase
   end

   assign read_idx = s_axi_araddr[3:2];
   assign read_oor = addr_out_of_range(s_axi_araddr);

   // Read state register; ARREADY follows the next state
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state       <= R_IDLE;
         s_axi_arready <= 1'b0;
      end else begin
         r_state       <= r_state_next;
         s_axi_arready <= (r_state_next == R_IDLE);
      end
   end

   // Capture read data from the pre-edge register contents and hold it until accepted
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         s_axi_rdata  <= '0;
         s_axi_rresp  <= RESP_OKAY;
         s_axi_rvalid <= 1'b0;
      end else begin
         if (ar_hs) begin
            s_axi_rvalid <= 1'b1;
            s_axi_rdata  <= read_oor ? '0 : regs[read_idx];
            s_axi_rresp  <= read_oor ? RESP_SLVERR : RESP_OKAY;
         end else if (s_axi_rvalid && s_axi_rready) begin
            s_axi_rvalid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_vfp_axi4lite_regfile.sv
// tb_vfp_axi4lite_regfile
// Directed plus randomized AXI4-Lite traffic against a simple array model of
// the four configuration registers. Built with a 5-bit address so that
// offsets 0x10 and above exercise the out-of-range response.

module tb_vfp_axi4lite_regfile;

   localparam int AW = 5;

   logic          clock = 1'b0;
   logic          reset;
   logic [AW-1:0] s_axi_awaddr;
   logic [2:0]    s_axi_awprot;
   logic          s_axi_awvalid;
   logic          s_axi_awready;
   logic [31:0]   s_axi_wdata;
   logic [3:0]    s_axi_wstrb;
   logic          s_axi_wvalid;
   logic          s_axi_wready;
   logic [1:0]    s_axi_bresp;
   logic          s_axi_bvalid;
   logic          s_axi_bready;
   logic [AW-1:0] s_axi_araddr;
   logic [2:0]    s_axi_arprot;
   logic          s_axi_arvalid;
   logic          s_axi_arready;
   logic [31:0]   s_axi_rdata;
   logic [1:0]    s_axi_rresp;
   logic          s_axi_rvalid;
   logic          s_axi_rready;
   logic [31:0]   cfg_reg0;
   logic [31:0]   cfg_reg1;
   logic [31:0]   cfg_reg2;
   logic [31:0]   cfg_reg3;
   logic [3:0]    cfg_wr_pulse;

   int errors = 0;
   int checks = 0;

   logic [31:0] model_regs [4];

   // Free-running 100 MHz clock
   always #5 clock = ~clock;

   vfp_axi4lite_regfile #(
      .C_S_AXI_DATA_WIDTH (32),
      .C_S_AXI_ADDR_WIDTH (AW)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .s_axi_awaddr  (s_axi_awaddr),
      .s_axi_awprot  (s_axi_awprot),
      .s_axi_awvalid (s_axi_awvalid),
      .s_axi_awready (s_axi_awready),
      .s_axi_wdata   (s_axi_wdata),
      .s_axi_wstrb   (s_axi_wstrb),
      .s_axi_wvalid  (s_axi_wvalid),
      .s_axi_wready  (s_axi_wready),
      .s_axi_bresp   (s_axi_bresp),
      .s_axi_bvalid  (s_axi_bvalid),
      .s_axi_bready  (s_axi_bready),
      .s_axi_araddr  (s_axi_araddr),
      .s_axi_arprot  (s_axi_arprot),
      .s_axi_arvalid (s_axi_arvalid),
      .s_axi_arready (s_axi_arready),
      .s_axi_rdata   (s_axi_rdata),
      .s_axi_rresp   (s_axi_rresp),
      .s_axi_rvalid  (s_axi_rvalid),
      .s_axi_rready  (s_axi_rready),
      .cfg_reg0      (cfg_reg0),
      .cfg_reg1      (cfg_reg1),
      .cfg_reg2      (cfg_reg2),
      .cfg_reg3      (cfg_reg3),
      .cfg_wr_pulse  (cfg_wr_pulse)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   task automatic checkCfg(input string tag);
      checkOutput({tag, "_cfg0"}, cfg_reg0, model_regs[0]);
      checkOutput({tag, "_cfg1"}, cfg_reg1, model_regs[1]);
      checkOutput({tag, "_cfg2"}, cfg_reg2, model_regs[2]);
      checkOutput({tag, "_cfg3"}, cfg_reg3, model_regs[3]);
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_awready"}, 32'(s_axi_awready), 32'd0);
      checkOutput({tag, "_wready"},  32'(s_axi_wready),  32'd0);
      checkOutput({tag, "_arready"}, 32'(s_axi_arready), 32'd0);
      checkOutput({tag, "_bvalid"},  32'(s_axi_bvalid),  32'd0);
      checkOutput({tag, "_bresp"},   32'(s_axi_bresp),   32'd0);
      checkOutput({tag, "_rvalid"},  32'(s_axi_rvalid),  32'd0);
      checkOutput({tag, "_rresp"},   32'(s_axi_rresp),   32'd0);
      checkOutput({tag, "_rdata"},   s_axi_rdata,        32'd0);
      checkOutput({tag, "_pulse"},   32'(cfg_wr_pulse),  32'd0);
      checkCfg(tag);
   endtask

   // One write transaction: AW and W raised at chosen cycles, BREADY delayed b_delay cycles
   task automatic axiWrite(input logic [AW-1:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_start, input int w_start, input int b_delay);
      logic       aw_done = 1'b0;
      logic       w_done = 1'b0;
      logic       aw_fire;
      logic       w_fire;
      logic [3:0] exp_pulse;
      logic [1:0] exp_resp;
      logic [1:0] idx;
      int         cyc = 0;
      s_axi_awaddr = addr;
      s_axi_wdata  = data;
      s_axi_wstrb  = strb;
      while (!(aw_done && w_done) && cyc < 40) begin
         if (cyc == aw_start) s_axi_awvalid = 1'b1;
         if (cyc == w_start)  s_axi_wvalid  = 1'b1;
         aw_fire = s_axi_awvalid && s_axi_awready;
         w_fire  = s_axi_wvalid && s_axi_wready;
         @(posedge clock); #1;
         cyc++;
         if (aw_fire) begin
            s_axi_awvalid = 1'b0;
            aw_done = 1'b1;
         end
         if (w_fire) begin
            s_axi_wvalid = 1'b0;
            w_done = 1'b1;
         end
         if (aw_done && !w_done) begin
            checkOutput("wait_w_awready", 32'(s_axi_awready), 32'd0);
            checkOutput("wait_w_wready",  32'(s_axi_wready),  32'd1);
            checkOutput("wait_w_bvalid",  32'(s_axi_bvalid),  32'd0);
         end
         if (w_done && !aw_done) begin
            checkOutput("wait_aw_wready",  32'(s_axi_wready),  32'd0);
            checkOutput("wait_aw_awready", 32'(s_axi_awready), 32'd1);
            checkOutput("wait_aw_bvalid",  32'(s_axi_bvalid),  32'd0);
         end
      end
      if (!(aw_done && w_done)) begin
         checkOutput("write_timeout", 32'd0, 32'd1);
         s_axi_awvalid = 1'b0;
         s_axi_wvalid  = 1'b0;
         return;
      end
      idx = addr[3:2];
      if (addr[4]) begin
         exp_resp  = 2'b10;
         exp_pulse = 4'b0000;
      end else begin
         exp_resp  = 2'b00;
         exp_pulse = 4'b0001 << idx;
         for (int b = 0; b < 4; b++) begin
            if (strb[b]) model_regs[idx][8*b +: 8] = data[8*b +: 8];
         end
      end
      checkOutput("commit_bvalid", 32'(s_axi_bvalid), 32'd1);
      checkOutput("commit_bresp",  32'(s_axi_bresp),  32'(exp_resp));
      checkOutput("commit_pulse",  32'(cfg_wr_pulse), 32'(exp_pulse));
      checkCfg("commit");
      for (int i = 0; i < b_delay; i++) begin
         @(posedge clock); #1;
         checkOutput("bhold_bvalid",  32'(s_axi_bvalid),  32'd1);
         checkOutput("bhold_bresp",   32'(s_axi_bresp),   32'(exp_resp));
         checkOutput("bhold_awready", 32'(s_axi_awready), 32'd0);
         checkOutput("bhold_wready",  32'(s_axi_wready),  32'd0);
      end
      s_axi_bready = 1'b1;
      @(posedge clock); #1;
      s_axi_bready = 1'b0;
      checkOutput("bdone_bvalid",  32'(s_axi_bvalid),  32'd0);
      checkOutput("bdone_pulse",   32'(cfg_wr_pulse),  32'd0);
      checkOutput("bdone_awready", 32'(s_axi_awready), 32'd1);
      checkOutput("bdone_wready",  32'(s_axi_wready),  32'd1);
   endtask

   // One read transaction: expected data taken from the model just before the AR edge
   task automatic axiRead(input logic [AW-1:0] addr, input int r_delay);
      logic        done = 1'b0;
      logic        fire;
      logic [31:0] exp_data = 32'd0;
      logic [1:0]  exp_resp = 2'b00;
      int          cyc = 0;
      s_axi_araddr  = addr;
      s_axi_arvalid = 1'b1;
      while (!done && cyc < 40) begin
         fire = s_axi_arvalid && s_axi_arready;
         if (fire) begin
            exp_data = addr[4] ? 32'd0 : model_regs[addr[3:2]];
            exp_resp = addr[4] ? 2'b10 : 2'b00;
         end
         @(posedge clock); #1;
         cyc++;
         if (fire) begin
            s_axi_arvalid = 1'b0;
            done = 1'b1;
         end
      end
      if (!done) begin
         checkOutput("read_timeout", 32'd0, 32'd1);
         s_axi_arvalid = 1'b0;
         return;
      end
      checkOutput("read_rvalid", 32'(s_axi_rvalid), 32'd1);
      checkOutput("read_rdata",  s_axi_rdata,       exp_data);
      checkOutput("read_rresp",  32'(s_axi_rresp),  32'(exp_resp));
      for (int i = 0; i < r_delay; i++) begin
         @(posedge clock); #1;
         checkOutput("rhold_rvalid",  32'(s_axi_rvalid),  32'd1);
         checkOutput("rhold_rdata",   s_axi_rdata,        exp_data);
         checkOutput("rhold_arready", 32'(s_axi_arready), 32'd0);
      end
      s_axi_rready = 1'b1;
      @(posedge clock); #1;
      s_axi_rready = 1'b0;
      checkOutput("rdone_rvalid",  32'(s_axi_rvalid),  32'd0);
      checkOutput("rdone_arready", 32'(s_axi_arready), 32'd1);
   endtask

   // Mixed random traffic, including concurrent read and write
   task automatic applyStimulus(input int count);
      logic [AW-1:0] wa;
      logic [AW-1:0] ra;
      logic [31:0]   wd;
      logic [3:0]    ws;
      int            mode;
      int            aws;
      int            ws_start;
      int            bd;
      int            rd;
      for (int n = 0; n < count; n++) begin
         wa       = {1'($urandom_range(0, 5) == 0), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
         ra       = {1'($urandom_range(0, 5) == 0), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
         wd       = $urandom;
         ws       = 4'($urandom_range(0, 15));
         mode     = $urandom_range(0, 2);
         aws      = $urandom_range(0, 3);
         ws_start = $urandom_range(0, 3);
         bd       = $urandom_range(0, 2);
         rd       = $urandom_range(0, 2);
         if (mode == 0) begin
            axiWrite(wa, wd, ws, aws, ws_start, bd);
         end else if (mode == 1) begin
            axiRead(ra, rd);
         end else begin
            fork
               axiWrite(wa, wd, ws, aws, ws_start, bd);
               axiRead(ra, rd);
            join
         end
      end
   endtask

   initial begin
      reset         = 1'b1;
      s_axi_awaddr  = '0;
      s_axi_awprot  = 3'd0;
      s_axi_awvalid = 1'b0;
      s_axi_wdata   = '0;
      s_axi_wstrb   = '0;
      s_axi_wvalid  = 1'b0;
      s_axi_bready  = 1'b0;
      s_axi_araddr  = '0;
      s_axi_arprot  = 3'd0;
      s_axi_arvalid = 1'b0;
      s_axi_rready  = 1'b0;
      for (int r = 0; r < 4; r++) model_regs[r] = 32'd0;

      // Reset state and readies rising on the first edge after release
      repeat (2) @(posedge clock);
      #1;
      checkAllZero("reset");
      reset = 1'b0;
      @(posedge clock); #1;
      checkOutput("release_awready", 32'(s_axi_awready), 32'd1);
      checkOutput("release_wready",  32'(s_axi_wready),  32'd1);
      checkOutput("release_arready", 32'(s_axi_arready), 32'd1);

      // Sequential writes with AW and W together, then readback
      for (int r = 0; r < 4; r++) axiWrite(AW'(4 * r), 32'(r + 1), 4'hF, 0, 0, 0);
      for (int r = 0; r < 4; r++) axiRead(AW'(4 * r), 0);
      checkOutput("seq_cfg3", cfg_reg3, 32'd4);

      // Address first, data three cycles later; then data first
      axiWrite(5'h08, 32'hDEADBEEF, 4'hF, 0, 3, 0);
      checkOutput("awfirst_cfg2", cfg_reg2, 32'hDEADBEEF);
      axiWrite(5'h08, 32'h00000000, 4'hF, 0, 0, 0);
      axiWrite(5'h08, 32'hDEADBEEF, 4'hF, 3, 0, 0);
      checkOutput("wfirst_cfg2", cfg_reg2, 32'hDEADBEEF);

      // Partial byte strobes, including an all-zero strobe
      axiWrite(5'h04, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
      axiWrite(5'h04, 32'h12345678, 4'b0101, 0, 0, 0);
      checkOutput("strobe_cfg1", cfg_reg1, 32'hFF34FF78);
      axiRead(5'h04, 0);
      axiWrite(5'h00, 32'h55555555, 4'b0000, 0, 0, 0);

      // Back-pressure on both response channels
      axiWrite(5'h0C, 32'hA5A5A5A5, 4'hF, 0, 0, 5);
      axiRead(5'h0C, 5);

      // Out-of-range accesses
      axiWrite(5'h10, 32'h000000AA, 4'hF, 0, 0, 0);
      axiRead(5'h10, 0);

      // Read and write to the same register on the same edge return the old value
      fork
         axiWrite(5'h00, 32'h0BADF00D, 4'hF, 0, 0, 0);
         axiRead(5'h00, 0);
      join
      axiRead(5'h00, 0);

      // Reset while the write is waiting for its data
      s_axi_awaddr  = 5'h04;
      s_axi_awvalid = 1'b1;
      @(posedge clock); #1;
      s_axi_awvalid = 1'b0;
      checkOutput("midrst_in_have_aw", 32'(s_axi_awready), 32'd0);
      #2;
      reset = 1'b1;
      #1;
      for (int r = 0; r < 4; r++) model_regs[r] = 32'd0;
      checkAllZero("midrst");
      @(posedge clock); #1;
      checkOutput("midrst_hold_bvalid", 32'(s_axi_bvalid), 32'd0);
      reset = 1'b0;
      @(posedge clock); #1;
      checkOutput("midrst_rel_awready", 32'(s_axi_awready), 32'd1);
      checkOutput("midrst_rel_wready",  32'(s_axi_wready),  32'd1);
      checkOutput("midrst_rel_arready", 32'(s_axi_arready), 32'd1);
      checkOutput("midrst_rel_bvalid",  32'(s_axi_bvalid),  32'd0);
      axiWrite(5'h04, 32'h13572468, 4'hF, 0, 0, 0);
      axiRead(5'h04, 0);

      applyStimulus(40);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
